bg_scene_ctl: RTL

BG_SCENE_CTL -- requirements
Module: bg_scene_ctl

---
 rtl/bg_scene_ctl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bg_scene_ctl.sv
// rtl/bg_scene_ctl.sv - vblank-synchronised scene/background arbiter for two requesters
// Optional frame counter output enabled by BG_SCENE_CTL_FRAME_CNT_EN.
module bg_scene_ctl #(
  parameter logic [1:0]  DEFAULT_SCENE = 2'd0,
  parameter logic [11:0] DEFAULT_COLOR = 12'h888
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [1:0]  req,
  input  logic [1:0]  scene_a,
  input  logic [1:0]  scene_b,
  input  logic [11:0] color_a,
  input  logic [11:0] color_b,
  output logic [1:0]  gnt,
  output logic        done,
  output logic        busy,
`ifdef BG_SCENE_CTL_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic [1:0]  scene,
  output logic [11:0] bg_color
);

  typedef enum logic [1:0] {IDLE, WAIT_VB, APPLY, DONE} state_t;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        win_q, win_d;
  logic [1:0]  gnt_q, gnt_d;
  logic        done_q, done_d;
  logic        vblnk_d_q, vblnk_d_d;
  logic [1:0]  sh_scene_q, sh_scene_d;
  logic [11:0] sh_color_q, sh_color_d;
  logic [1:0]  scene_q, scene_d;
  logic [11:0] color_q, color_d;
  logic        frame_edge;
  logic        win;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    done_d     = 1'b0;
    vblnk_d_d  = vblnk;
    sh_scene_d = sh_scene_q;
    sh_color_d = sh_color_q;
    scene_d    = scene_q;
    color_d    = color_q;
    frame_edge = vblnk & ~vblnk_d_q;
    win        = (req == 2'b11) ? ptr_q : req[1];

    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d      = win;
          sh_scene_d = win ? scene_b : scene_a;
          sh_color_d = win ? color_b : color_a;
          gnt_d      = win ? 2'b10 : 2'b01;
          state_d    = WAIT_VB;
        end
      end
      WAIT_VB: begin
        // A withdrawn request wins over a coincident frame edge.
        if (!req[win_q]) begin
          gnt_d   = 2'b00;
          state_d = IDLE;
        end else if (frame_edge) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        scene_d = sh_scene_q;
        color_d = sh_color_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ptr_d   = ~win_q;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 1'b0;
      vblnk_d_q  <= 1'b0;
      sh_scene_q <= DEFAULT_SCENE;
      sh_color_q <= DEFAULT_COLOR;
      scene_q    <= DEFAULT_SCENE;
      color_q    <= DEFAULT_COLOR;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      vblnk_d_q  <= vblnk_d_d;
      sh_scene_q <= sh_scene_d;
      sh_color_q <= sh_color_d;
      scene_q    <= scene_d;
      color_q    <= color_d;
    end
  end

`ifdef BG_SCENE_CTL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_edge) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= 16'd0;
    else     frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);
  assign scene    = scene_q;
  assign bg_color = color_q;

endmodule
